// File: rtl/lsu_router_pkg.sv
// Shared definitions for the LSU address router: default memory map,
// target index type and the region match helper.
package lsu_router_pkg;

  localparam int MAX_SLAVES = 8;
  localparam int MAX_AW     = 64;

  localparam logic [31:0] INSTR_BASE = 32'h1000_0000;
  localparam logic [31:0] INSTR_MASK = 32'hFFFF_0000;
  localparam logic [31:0] DATA_BASE  = 32'h2000_0000;
  localparam logic [31:0] DATA_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] UART_BASE  = 32'h3000_0000;
  localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;

  // Wide enough for every slave plus the error responder slot.
  typedef logic [$clog2(MAX_SLAVES+1)-1:0] tgt_idx_t;

  function automatic logic region_match(
    input logic [MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0] base,
    input logic [MAX_AW-1:0] mask
  );
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/lsu_router_decode.sv
// Address decoder: picks the lowest-index matching region, falling back
// to the error responder slot, and computes the in-region offset.
module lsu_router_decode
  import lsu_router_pkg::*;
#(
  parameter int N_SLAVES   = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int TW         = 2,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] REGION_BASE =
    {UART_BASE, DATA_BASE, INSTR_BASE},
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] REGION_MASK =
    {UART_MASK, DATA_MASK, INSTR_MASK}
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [TW-1:0]         tgt_o,
  output logic [ADDR_WIDTH-1:0] offset_o
);

  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] mask;

  // Walk from the top so the lowest matching index is the last writer.
  always_comb begin
    tgt_o    = TW'(N_SLAVES);
    offset_o = addr_i;
    base     = '0;
    mask     = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      base = REGION_BASE[i*ADDR_WIDTH +: ADDR_WIDTH];
      mask = REGION_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      if (region_match(MAX_AW'(addr_i),
                       MAX_AW'(base),
                       MAX_AW'(mask))) begin
        tgt_o    = TW'(i);
        offset_o = addr_i - base;
      end
    end
  end

endmodule

// File: rtl/lsu_addr_router.sv
// In-order N-way router from a core req/gnt/rvalid port to mapped targets.
// Define LSU_ROUTER_ERR_CAPTURE_EN to add first-error address capture.
module lsu_addr_router
  import lsu_router_pkg::*;
#(
  parameter int N_SLAVES        = 3,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] REGION_BASE =
    {UART_BASE, DATA_BASE, INSTR_BASE},
  parameter logic [N_SLAVES*ADDR_WIDTH-1:0] REGION_MASK =
    {UART_MASK, DATA_MASK, INSTR_MASK}
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           m_req_i,
  output logic                           m_gnt_o,
  input  logic [ADDR_WIDTH-1:0]          m_addr_i,
  input  logic                           m_we_i,
  input  logic [DATA_WIDTH/8-1:0]        m_be_i,
  input  logic [DATA_WIDTH-1:0]          m_wdata_i,
  output logic                           m_rvalid_o,
  output logic [DATA_WIDTH-1:0]          m_rdata_o,
  output logic                           m_err_o,
  output logic [N_SLAVES-1:0]            s_req_o,
  input  logic [N_SLAVES-1:0]            s_gnt_i,
  output logic [ADDR_WIDTH-1:0]          s_addr_o,
  output logic                           s_we_o,
  output logic [DATA_WIDTH/8-1:0]        s_be_o,
  output logic [DATA_WIDTH-1:0]          s_wdata_o,
  input  logic [N_SLAVES-1:0]            s_rvalid_i,
  input  logic [N_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
  input  logic [N_SLAVES-1:0]            s_err_i
`ifdef LSU_ROUTER_ERR_CAPTURE_EN
  ,
  output logic                           err_valid_o,
  output logic [ADDR_WIDTH-1:0]          err_addr_o,
  input  logic                           err_clr_i
`endif
);

  localparam int TW = $clog2(N_SLAVES + 1);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TW-1:0] ERR_IDX = TW'(N_SLAVES);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] cur_q, cur_d;
  logic [CW-1:0] err_pend_q, err_pend_d;

  logic [TW-1:0]         tgt;
  logic [ADDR_WIDTH-1:0] offset;
  logic                  tgt_is_err;
  logic                  cur_err;
  logic                  busy;
  logic                  full;
  logic                  stall;
  logic                  fwd;
  logic                  acc;
  logic                  rsp;
  logic                  sel_gnt;
  logic                  sel_rvalid;
  logic                  sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  lsu_router_decode #(
    .N_SLAVES    (N_SLAVES),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .TW          (TW),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decode (
    .addr_i   (m_addr_i),
    .tgt_o    (tgt),
    .offset_o (offset)
  );

  assign tgt_is_err = (tgt == ERR_IDX);
  assign cur_err    = (cur_q == ERR_IDX);
  assign busy       = (cnt_q != '0);
  assign full       = (cnt_q == CNT_MAX);

  always_comb begin
    sel_gnt    = 1'b0;
    sel_rvalid = 1'b0;
    sel_err    = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (tgt == TW'(i)) begin
        sel_gnt = s_gnt_i[i];
      end
      if (cur_q == TW'(i)) begin
        sel_rvalid = s_rvalid_i[i];
        sel_err    = s_err_i[i];
        sel_rdata  = s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Responses only count while something is outstanding; the error
  // responder answers one cycle after each of its acceptances.
  always_comb begin
    rsp = 1'b0;
    if (busy) begin
      rsp = cur_err ? (err_pend_q != '0) : sel_rvalid;
    end
  end

  assign m_rvalid_o = rsp;
  assign m_err_o    = rsp & (cur_err | sel_err);
  assign m_rdata_o  = (rsp && !cur_err) ? sel_rdata : '0;

  // Switching targets waits for a full drain so responses stay ordered.
  assign stall = (busy && (tgt != cur_q)) || (full && !rsp);
  assign fwd   = m_req_i && !stall && !rst;

  always_comb begin
    s_req_o = '0;
    if (fwd && !tgt_is_err) begin
      for (int i = 0; i < N_SLAVES; i++) begin
        if (tgt == TW'(i)) begin
          s_req_o[i] = 1'b1;
        end
      end
    end
  end

  assign m_gnt_o = fwd && (tgt_is_err || sel_gnt);
  assign acc     = m_req_i && m_gnt_o;

  assign s_addr_o  = offset;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  always_comb begin
    unique case (1'b1)
      (acc && !rsp): cnt_d = cnt_q + 1'b1;
      (rsp && !acc): cnt_d = cnt_q - 1'b1;
      default:       cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    cur_d = cur_q;
    if (acc) begin
      cur_d = tgt;
    end
  end

  always_comb begin
    err_pend_d = err_pend_q;
    if (acc && tgt_is_err) begin
      err_pend_d = err_pend_d + 1'b1;
    end
    if (rsp && cur_err) begin
      err_pend_d = err_pend_d - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      cur_q      <= '0;
      err_pend_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      err_pend_q <= err_pend_d;
    end
  end

`ifdef LSU_ROUTER_ERR_CAPTURE_EN
  localparam int PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

  logic [ADDR_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
  logic [ADDR_WIDTH-1:0] fifo_d [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  cap_valid_q, cap_valid_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q, cap_addr_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Request addresses ride along in order so a response can name its fault.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (acc) begin
      fifo_d[wr_ptr_q] = m_addr_i;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (rsp) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
  end

  always_comb begin
    cap_valid_d = cap_valid_q;
    cap_addr_d  = cap_addr_q;
    if (err_clr_i) begin
      cap_valid_d = 1'b0;
      cap_addr_d  = '0;
    end else if (m_rvalid_o && m_err_o && !cap_valid_q) begin
      cap_valid_d = 1'b1;
      cap_addr_d  = fifo_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cap_valid_q <= 1'b0;
      cap_addr_q  <= '0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cap_valid_q <= cap_valid_d;
      cap_addr_q  <= cap_addr_d;
    end
  end

  assign err_valid_o = cap_valid_q;
  assign err_addr_o  = cap_addr_q;
`endif

endmodule

// File: tb/tb_lsu_addr_router.sv
// Directed plus randomized bench for lsu_addr_router against a
// queue-based model of outstanding transactions.
module tb_lsu_addr_router;

  localparam int NS   = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXO = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              m_req_i = 1'b0;
  logic              m_gnt_o;
  logic [AW-1:0]     m_addr_i = '0;
  logic              m_we_i = 1'b0;
  logic [DW/8-1:0]   m_be_i = '0;
  logic [DW-1:0]     m_wdata_i = '0;
  logic              m_rvalid_o;
  logic [DW-1:0]     m_rdata_o;
  logic              m_err_o;
  logic [NS-1:0]     s_req_o;
  logic [NS-1:0]     s_gnt_i = '0;
  logic [AW-1:0]     s_addr_o;
  logic              s_we_o;
  logic [DW/8-1:0]   s_be_o;
  logic [DW-1:0]     s_wdata_o;
  logic [NS-1:0]     s_rvalid_i = '0;
  logic [NS*DW-1:0]  s_rdata_i;
  logic [NS-1:0]     s_err_i = '0;
  logic [DW-1:0]     rd [NS];

  int n_cmp = 0;
  int n_bad = 0;
  int q[$];

  logic              obs_gnt;
  logic              obs_rv;
  logic              obs_err;
  logic [NS-1:0]     obs_sreq;
  logic [AW-1:0]     obs_saddr;
  logic [DW-1:0]     obs_rdata;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NS; i++) s_rdata_i[i*DW +: DW] = rd[i];
  end

  lsu_addr_router dut (
    .clk        (clk),
    .rst        (rst),
    .m_req_i    (m_req_i),
    .m_gnt_o    (m_gnt_o),
    .m_addr_i   (m_addr_i),
    .m_we_i     (m_we_i),
    .m_be_i     (m_be_i),
    .m_wdata_i  (m_wdata_i),
    .m_rvalid_o (m_rvalid_o),
    .m_rdata_o  (m_rdata_o),
    .m_err_o    (m_err_o),
    .s_req_o    (s_req_o),
    .s_gnt_i    (s_gnt_i),
    .s_addr_o   (s_addr_o),
    .s_we_o     (s_we_o),
    .s_be_o     (s_be_o),
    .s_wdata_o  (s_wdata_o),
    .s_rvalid_i (s_rvalid_i),
    .s_rdata_i  (s_rdata_i),
    .s_err_i    (s_err_i)
  );

  function automatic logic [31:0] rbase(input int i);
    case (i)
      0: return 32'h1000_0000;
      1: return 32'h2000_0000;
      default: return 32'h3000_0000;
    endcase
  endfunction

  function automatic logic [31:0] rmask(input int i);
    case (i)
      0: return 32'hFFFF_0000;
      1: return 32'hFFFF_0000;
      default: return 32'hFFFF_F000;
    endcase
  endfunction

  function automatic void decode(input logic [31:0] a,
                                 output int t,
                                 output logic [31:0] off);
    t = NS;
    off = a;
    for (int i = 0; i < NS; i++) begin
      if (t == NS && (a & rmask(i)) == (rbase(i) & rmask(i))) begin
        t = i;
        off = a - rbase(i);
      end
    end
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: compare at the negedge, advance the model at the posedge.
  task automatic step();
    int          t;
    logic [31:0] off;
    logic        rsp;
    logic        stall;
    logic        e_gnt;
    logic        e_err;
    logic [31:0] e_rd;
    logic [NS-1:0] e_sreq;
    @(negedge clk);
    decode(m_addr_i, t, off);
    rsp = 1'b0;
    e_err = 1'b0;
    e_rd = '0;
    if (!rst && q.size() > 0) begin
      if (q[0] == NS) begin
        rsp = 1'b1;
        e_err = 1'b1;
      end else begin
        rsp = s_rvalid_i[q[0]];
        e_err = s_err_i[q[0]];
        e_rd = rd[q[0]];
      end
    end
    stall = (q.size() > 0 && t != q[0]) || (q.size() == MAXO && !rsp);
    e_gnt = 1'b0;
    e_sreq = '0;
    if (!rst && m_req_i && !stall) begin
      e_gnt = (t == NS) ? 1'b1 : s_gnt_i[t];
      if (t < NS) e_sreq[t] = 1'b1;
    end
    obs_gnt = m_gnt_o;
    obs_rv = m_rvalid_o;
    obs_err = m_err_o;
    obs_sreq = s_req_o;
    obs_saddr = s_addr_o;
    obs_rdata = m_rdata_o;
    chk("m_gnt", m_gnt_o, e_gnt);
    chk("s_req", s_req_o, e_sreq);
    chk("m_rvalid", m_rvalid_o, rsp);
    if (rsp) begin
      chk("m_err", m_err_o, e_err);
      chk("m_rdata", m_rdata_o, e_rd);
    end
    if (e_sreq != '0) begin
      chk("s_addr", s_addr_o, off);
      chk("s_we", s_we_o, m_we_i);
      chk("s_be", s_be_o, m_be_i);
      chk("s_wdata", s_wdata_o, m_wdata_i);
    end
    @(posedge clk);
    if (rst) q.delete();
    else begin
      if (rsp) void'(q.pop_front());
      if (e_gnt) q.push_back(t);
    end
    #1;
  endtask

  task automatic drive(input logic req, input logic [31:0] a,
                       input logic [NS-1:0] gnt,
                       input logic [NS-1:0] rv);
    m_req_i = req;
    m_addr_i = a;
    s_gnt_i = gnt;
    s_rvalid_i = rv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < NS; i++) rd[i] = '0;
    m_be_i = 4'hF;
    @(posedge clk);
    #1;
    // Reset forces the request side quiet even with a live request.
    drive(1'b1, 32'h2000_0000, 3'b111, 3'b000);
    step();
    chk("rst_gnt", obs_gnt, 1'b0);
    chk("rst_sreq", obs_sreq, 3'b000);
    chk("rst_rvalid", obs_rv, 1'b0);
    chk("rst_err", obs_err, 1'b0);
    chk("rst_rdata", obs_rdata, 32'h0);
    rst = 1'b0;

    // Data-memory read with one-cycle response.
    drive(1'b1, 32'h2000_0010, 3'b010, 3'b000);
    step();
    chk("rd_sreq", obs_sreq, 3'b010);
    chk("rd_saddr", obs_saddr, 32'h10);
    chk("rd_gnt", obs_gnt, 1'b1);
    rd[1] = 32'hDEAD_BEEF;
    drive(1'b0, 32'h0, 3'b000, 3'b010);
    step();
    chk("rd_rvalid", obs_rv, 1'b1);
    chk("rd_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk("rd_err", obs_err, 1'b0);

    // Fill to the outstanding limit; the fifth waits for a response.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h1000_0000 + 32'(4 * k), 3'b001, 3'b000);
      step();
      chk("b2b_gnt", obs_gnt, 1'b1);
    end
    drive(1'b1, 32'h1000_0010, 3'b001, 3'b000);
    step();
    chk("full_stall", obs_gnt, 1'b0);
    rd[0] = 32'h1111_0000;
    drive(1'b1, 32'h1000_0010, 3'b001, 3'b001);
    step();
    chk("full_rsp_gnt", obs_gnt, 1'b1);
    chk("full_rsp_rv", obs_rv, 1'b1);
    for (int k = 0; k < 4; k++) begin
      rd[0] = 32'h1111_0001 + 32'(k);
      drive(1'b0, 32'h0, 3'b000, 3'b001);
      step();
      chk("drain_rv", obs_rv, 1'b1);
    end

    // Target switch waits for the data-memory read to drain.
    drive(1'b1, 32'h2000_0000, 3'b111, 3'b000);
    step();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h3000_0004, 3'b111, 3'b000);
      step();
      chk("sw_stall", obs_gnt, 1'b0);
      chk("sw_sreq", obs_sreq, 3'b000);
    end
    rd[1] = 32'h0BAD_F00D;
    drive(1'b1, 32'h3000_0004, 3'b111, 3'b010);
    step();
    chk("sw_drain_rv", obs_rv, 1'b1);
    chk("sw_drain_gnt", obs_gnt, 1'b0);
    drive(1'b1, 32'h3000_0004, 3'b111, 3'b000);
    step();
    chk("sw_gnt", obs_gnt, 1'b1);
    chk("sw_uart_sreq", obs_sreq, 3'b100);
    chk("sw_uart_addr", obs_saddr, 32'h4);
    rd[2] = 32'h0000_0055;
    drive(1'b0, 32'h0, 3'b000, 3'b100);
    step();

    // Unmapped write goes to the error responder.
    m_we_i = 1'b1;
    drive(1'b1, 32'h5000_0000, 3'b000, 3'b000);
    step();
    chk("err_gnt", obs_gnt, 1'b1);
    chk("err_sreq", obs_sreq, 3'b000);
    m_we_i = 1'b0;
    rd[0] = 32'hFFFF_FFFF;
    drive(1'b0, 32'h0, 3'b000, 3'b000);
    step();
    chk("err_rv", obs_rv, 1'b1);
    chk("err_err", obs_err, 1'b1);
    chk("err_rdata", obs_rdata, 32'h0);

    // Spurious response while idle.
    drive(1'b0, 32'h0, 3'b000, 3'b100);
    step();
    chk("spur_rv", obs_rv, 1'b0);

    // Reset with two outstanding discards them.
    drive(1'b1, 32'h2000_0100, 3'b010, 3'b000);
    step();
    step();
    drive(1'b0, 32'h0, 3'b000, 3'b000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(1'b0, 32'h0, 3'b000, 3'b010);
    step();
    chk("late_rv", obs_rv, 1'b0);

    // Randomized traffic, including spurious responses and reset pulses.
    a = 32'h1000_0000;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0: a = 32'h1000_0000 | ($urandom & 32'hFFFF);
        1: a = 32'h2000_0000 | ($urandom & 32'hFFFF);
        2: a = 32'h3000_0000 | ($urandom & 32'hFFF);
        3: a = 32'h3000_1000 | ($urandom & 32'hFFF);
        4: a = $urandom;
        default: ;
      endcase
      m_we_i = 1'($urandom);
      m_be_i = 4'($urandom);
      m_wdata_i = $urandom;
      s_err_i = ($urandom_range(0, 7) == 0) ? NS'($urandom) : '0;
      for (int i = 0; i < NS; i++) rd[i] = $urandom;
      drive($urandom_range(0, 9) < 7, a, NS'($urandom), NS'($urandom));
      rst = ($urandom_range(0, 199) == 0);
      step();
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
